// File: rtl/hyperbus_pkg.sv
// Shared Hyperbus types.
//   hyper_cfg_t   : timing configuration from the register file
//   rule_t        : per-chip address rule, end_addr is exclusive
//   hyper_sub_t   : one chip-local sub-burst, sized for the default geometry
//   split_state_e : burst splitter FSM states
package hyperbus_pkg;

  localparam int unsigned NUM_CHIPS_DEFAULT   = 2;
  localparam int unsigned ADDR_WIDTH_DEFAULT  = 32;
  localparam int unsigned LEN_WIDTH_DEFAULT   = 16;
  localparam int unsigned CS_OVERHEAD_DEFAULT = 16;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [3:0]  t_tx_clk_delay;
    logic [4:0]  address_mask_msb;
    logic        address_space;
    logic [15:0] t_cs_max;
  } hyper_cfg_t;

  typedef struct packed {
    logic [31:0]                   idx;
    logic [ADDR_WIDTH_DEFAULT-1:0] start_addr;
    logic [ADDR_WIDTH_DEFAULT-1:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic [NUM_CHIPS_DEFAULT-1:0]  cs;
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [LEN_WIDTH_DEFAULT-1:0]  len;
    logic                          write;
    logic                          last;
  } hyper_sub_t;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StIssue,
    StErr
  } split_state_e;

endpackage

// File: rtl/hyperbus_chip_decode.sv
// Combinational address-to-chip decoder.
//   addr_i       : byte address to look up
//   rules_i      : per-chip rules, lowest index has priority on overlap
//   match_o      : some rule covers addr_i
//   idx_o        : array position of the winning rule
//   start_addr_o : start of the winning rule (0 when no match)
//   end_addr_o   : exclusive end of the winning rule (0 when no match)
module hyperbus_chip_decode
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips  = NUM_CHIPS_DEFAULT,
  parameter int unsigned AddrWidth = ADDR_WIDTH_DEFAULT,
  parameter int unsigned IdxWidth  = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  rule_t [NumChips-1:0] rules_i,
  output logic                 match_o,
  output logic [IdxWidth-1:0]  idx_o,
  output logic [AddrWidth-1:0] start_addr_o,
  output logic [AddrWidth-1:0] end_addr_o
);

  logic [NumChips-1:0] hit;
  logic [NumChips-1:0] unused_rule_idx;

  for (genvar g = 0; g < NumChips; g++) begin : g_hit
    assign hit[g] = (addr_i >= AddrWidth'(rules_i[g].start_addr)) &&
                    (addr_i <  AddrWidth'(rules_i[g].end_addr));
    assign unused_rule_idx[g] = ^rules_i[g].idx;
  end

  // Walk from the top so the lowest matching index is the last writer.
  always_comb begin
    match_o      = 1'b0;
    idx_o        = '0;
    start_addr_o = '0;
    end_addr_o   = '0;
    for (int i = int'(NumChips) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_o      = 1'b1;
        idx_o        = IdxWidth'(i);
        start_addr_o = AddrWidth'(rules_i[i].start_addr);
        end_addr_o   = AddrWidth'(rules_i[i].end_addr);
      end
    end
  end

endmodule

// File: rtl/hyperbus_burst_splitter.sv
// Splits linear word bursts into chip-local sub-bursts that never cross a
// chip end address and never exceed the CS-low budget (t_cs_max - CsOverhead).
//   cfg_i, chip_rules_i        : config, snapshotted when a transaction is taken
//   trans_valid_i/trans_ready_o: incoming transaction handshake
//   trans_addr_i/len_i/write_i : byte address (bit 0 ignored), word length, dir
//   trans_err_o                : one-cycle pulse on reject/abort
//   sub_valid_o/sub_ready_i    : outgoing sub-burst handshake
//   sub_cs_o/addr_o/len_o      : one-hot CS, chip-local address, word length
//   sub_write_o/sub_last_o     : direction, final sub-burst of the transaction
//   busy_o                     : a transaction is in flight
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips   = NUM_CHIPS_DEFAULT,
  parameter int unsigned AddrWidth  = ADDR_WIDTH_DEFAULT,
  parameter int unsigned LenWidth   = LEN_WIDTH_DEFAULT,
  parameter int unsigned CsOverhead = CS_OVERHEAD_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  hyper_cfg_t           cfg_i,
  input  rule_t [NumChips-1:0] chip_rules_i,
  input  logic                 trans_valid_i,
  output logic                 trans_ready_o,
  input  logic [AddrWidth-1:0] trans_addr_i,
  input  logic [LenWidth-1:0]  trans_len_i,
  input  logic                 trans_write_i,
  output logic                 trans_err_o,
  output logic                 sub_valid_o,
  input  logic                 sub_ready_i,
  output logic [NumChips-1:0]  sub_cs_o,
  output logic [AddrWidth-1:0] sub_addr_o,
  output logic [LenWidth-1:0]  sub_len_o,
  output logic                 sub_write_o,
  output logic                 sub_last_o,
  output logic                 busy_o
);

  localparam int unsigned IdxWidth = (NumChips > 1) ? $clog2(NumChips) : 1;
  localparam logic [AddrWidth-1:0] LenMax = AddrWidth'({LenWidth{1'b1}});

  split_state_e         state_q, state_d;
  logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic [LenWidth-1:0]  limit_q, limit_d;
  logic                 write_q, write_d;
  logic                 wrapped_q, wrapped_d;
  rule_t [NumChips-1:0] rules_q, rules_d;
  hyper_sub_t           sub_q, sub_d;

  logic                 dec_match;
  logic [IdxWidth-1:0]  dec_idx;
  logic [AddrWidth-1:0] dec_start, dec_end;

  logic [AddrWidth-1:0] t_cs_wide, limit_wide;
  logic [AddrWidth-1:0] word_dist, len_wide;
  logic [AddrWidth:0]   next_addr;
  logic                 unused_inputs;

  assign unused_inputs = ^{cfg_i, trans_addr_i[0]};

  hyperbus_chip_decode #(
    .NumChips  (NumChips),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_chip_decode (
    .addr_i       (cur_addr_q),
    .rules_i      (rules_q),
    .match_o      (dec_match),
    .idx_o        (dec_idx),
    .start_addr_o (dec_start),
    .end_addr_o   (dec_end)
  );

  // Per-sub-burst word budget from the live config; only latched in IDLE.
  always_comb begin
    t_cs_wide = AddrWidth'(cfg_i.t_cs_max);
    if (t_cs_wide > AddrWidth'(CsOverhead)) begin
      limit_wide = t_cs_wide - AddrWidth'(CsOverhead);
    end else begin
      limit_wide = AddrWidth'(1);
    end
    if (limit_wide > LenMax) begin
      limit_wide = LenMax;
    end
  end

  // Sub-burst length = min(remaining, words to chip end, budget).
  always_comb begin
    word_dist = (dec_end - cur_addr_q) >> 1;
    len_wide  = AddrWidth'(remaining_q);
    if (word_dist < len_wide) begin
      len_wide = word_dist;
    end
    if (AddrWidth'(limit_q) < len_wide) begin
      len_wide = AddrWidth'(limit_q);
    end
  end

  // Carry out marks a wrap past the top of the address space.
  assign next_addr = {1'b0, cur_addr_q} + (AddrWidth + 1)'({sub_q.len, 1'b0});

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    limit_d       = limit_q;
    write_d       = write_q;
    wrapped_d     = wrapped_q;
    rules_d       = rules_q;
    sub_d         = sub_q;
    trans_ready_o = 1'b0;
    trans_err_o   = 1'b0;
    sub_valid_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        trans_ready_o = 1'b1;
        if (trans_valid_i) begin
          cur_addr_d  = {trans_addr_i[AddrWidth-1:1], 1'b0};
          remaining_d = trans_len_i;
          write_d     = trans_write_i;
          wrapped_d   = 1'b0;
          rules_d     = chip_rules_i;
          limit_d     = LenWidth'(limit_wide);
          state_d     = (trans_len_i == '0) ? StErr : StDecode;
        end
      end
      StDecode: begin
        if (!dec_match || wrapped_q || (word_dist == '0)) begin
          state_d = StErr;
        end else begin
          sub_d.cs    = NumChips'(1) << dec_idx;
          sub_d.addr  = cur_addr_q - dec_start;
          sub_d.len   = LenWidth'(len_wide);
          sub_d.write = write_q;
          sub_d.last  = (LenWidth'(len_wide) == remaining_q);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        sub_valid_o = 1'b1;
        if (sub_ready_i) begin
          cur_addr_d  = next_addr[AddrWidth-1:0];
          wrapped_d   = next_addr[AddrWidth];
          remaining_d = remaining_q - sub_q.len;
          state_d     = sub_q.last ? StIdle : StDecode;
        end
      end
      StErr: begin
        trans_err_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      limit_q     <= '0;
      write_q     <= 1'b0;
      wrapped_q   <= 1'b0;
      rules_q     <= '0;
      sub_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      limit_q     <= limit_d;
      write_q     <= write_d;
      wrapped_q   <= wrapped_d;
      rules_q     <= rules_d;
      sub_q       <= sub_d;
    end
  end

  assign sub_cs_o    = sub_q.cs;
  assign sub_addr_o  = sub_q.addr;
  assign sub_len_o   = sub_q.len;
  assign sub_write_o = sub_q.write;
  assign sub_last_o  = sub_q.last;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
module tb_hyperbus_burst_splitter;
  import hyperbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  hyper_cfg_t  cfg;
  rule_t [1:0] rules;
  logic        trans_valid, trans_ready, trans_write, trans_err;
  logic [31:0] trans_addr;
  logic [15:0] trans_len;
  logic        sub_valid, sub_ready, sub_write, sub_last, busy;
  logic [1:0]  sub_cs;
  logic [31:0] sub_addr;
  logic [15:0] sub_len;

  always #5 clk = ~clk;

  hyperbus_burst_splitter u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_i         (cfg),
    .chip_rules_i  (rules),
    .trans_valid_i (trans_valid),
    .trans_ready_o (trans_ready),
    .trans_addr_i  (trans_addr),
    .trans_len_i   (trans_len),
    .trans_write_i (trans_write),
    .trans_err_o   (trans_err),
    .sub_valid_o   (sub_valid),
    .sub_ready_i   (sub_ready),
    .sub_cs_o      (sub_cs),
    .sub_addr_o    (sub_addr),
    .sub_len_o     (sub_len),
    .sub_write_o   (sub_write),
    .sub_last_o    (sub_last),
    .busy_o        (busy)
  );

  typedef struct {
    logic [1:0]  cs;
    logic [31:0] addr;
    int          len;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_err;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic default_rules();
    for (int i = 0; i < 2; i++) begin
      rules[i].idx        = i;
      rules[i].start_addr = 32'h40_0000 * i;
      rules[i].end_addr   = 32'h40_0000 * (i + 1);
    end
  endtask

  // Reference: walk the burst word-range through the rules with plain arithmetic.
  function automatic void build_model(input logic [31:0] addr, input int len, input int tcs);
    longint a, s, e, n, lim;
    int     rem, hit;
    exp_t   x;
    exp_q.delete();
    exp_err = 1'b0;
    a   = {32'd0, addr & 32'hFFFF_FFFE};
    rem = len;
    lim = (tcs > 16) ? tcs - 16 : 1;
    if (lim > 65535) lim = 65535;
    if (len == 0) begin
      exp_err = 1'b1;
      return;
    end
    while (rem > 0) begin
      hit = -1;
      for (int i = 1; i >= 0; i--) begin
        s = {32'd0, rules[i].start_addr};
        e = {32'd0, rules[i].end_addr};
        if (a >= s && a < e) hit = i;
      end
      if (hit < 0 || ({32'd0, rules[hit].end_addr} - a) / 2 == 0) begin
        exp_err = 1'b1;
        return;
      end
      s = {32'd0, rules[hit].start_addr};
      e = {32'd0, rules[hit].end_addr};
      n = rem;
      if ((e - a) / 2 < n) n = (e - a) / 2;
      if (lim < n) n = lim;
      x.cs   = 2'(1 << hit);
      x.addr = 32'(a - s);
      x.len  = int'(n);
      x.last = (n == rem);
      exp_q.push_back(x);
      a   = a + 2 * n;
      rem = rem - int'(n);
    end
  endfunction

  // Drive one transaction at a negedge and check every cycle until IDLE.
  // gap < 0 picks a random backpressure per sub-burst.
  task automatic run_txn(input logic [31:0] addr, input int len, input bit wr, input int gap,
                         input bit mutate);
    int          g;
    logic [15:0] saved_tcs;
    saved_tcs = cfg.t_cs_max;
    build_model(addr, len, int'(cfg.t_cs_max));
    chk("idle_ready", trans_ready, 1);
    trans_valid = 1'b1;
    trans_addr  = addr;
    trans_len   = 16'(len);
    trans_write = wr;
    @(negedge clk);
    trans_valid = 1'b0;
    foreach (exp_q[k]) begin
      chk("decode_no_valid", sub_valid, 0);
      chk("decode_busy", busy, 1);
      @(negedge clk);
      chk("sub_valid_latency", sub_valid, 1);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int c = 0; c <= g; c++) begin
        chk("sub_cs", sub_cs, exp_q[k].cs);
        chk("sub_addr", sub_addr, exp_q[k].addr);
        chk("sub_len", sub_len, exp_q[k].len);
        chk("sub_write", sub_write, wr);
        chk("sub_last", sub_last, exp_q[k].last);
        if (c < g) begin
          if (mutate && k == 0 && c == 1) begin
            rules[0].end_addr   = 32'h10;
            rules[1].start_addr = 32'h100_0000;
            rules[1].end_addr   = 32'h200_0000;
            cfg.t_cs_max        = 16'd10;
          end
          @(negedge clk);
          chk("hold_valid", sub_valid, 1);
        end
      end
      sub_ready = 1'b1;
      @(negedge clk);
      sub_ready = 1'b0;
    end
    if (exp_err) begin
      if (len != 0) begin
        chk("err_decode", trans_err, 0);
        @(negedge clk);
      end
      chk("err_pulse", trans_err, 1);
      chk("err_no_valid", sub_valid, 0);
      @(negedge clk);
      chk("err_pulse_end", trans_err, 0);
      chk("err_ready_back", trans_ready, 1);
    end else begin
      chk("done_ready", trans_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", sub_valid, 0);
      chk("done_no_err", trans_err, 0);
    end
    if (mutate) begin
      default_rules();
      cfg.t_cs_max = saved_tcs;
    end
  endtask

  initial begin
    int   tcs, len, sel;
    logic [31:0] addr;
    cfg         = '0;
    cfg.t_cs_max = 16'd665;
    default_rules();
    trans_valid = 1'b0;
    trans_addr  = '0;
    trans_len   = '0;
    trans_write = 1'b0;
    sub_ready   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", trans_ready, 1);
    chk("rst_valid", sub_valid, 0);
    chk("rst_err", trans_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", sub_cs, 0);
    chk("rst_addr", sub_addr, 0);
    chk("rst_len", sub_len, 0);
    chk("rst_last", sub_last, 0);
    chk("rst_write", sub_write, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(32'h100, 8, 1'b1, 0, 1'b0);
    run_txn(32'h3F_FFF0, 16, 1'b0, 0, 1'b0);
    run_txn(32'h0, 1000, 1'b1, 1, 1'b0);
    cfg.t_cs_max = 16'd10;
    run_txn(32'h3F_FFFA, 5, 1'b0, 0, 1'b0);
    cfg.t_cs_max = 16'd665;
    run_txn(32'h80_0000, 4, 1'b0, 0, 1'b0);
    run_txn(32'h7F_FFFC, 4, 1'b1, 0, 1'b0);
    run_txn(32'h200, 0, 1'b0, 0, 1'b0);
    run_txn(32'h3F_FFF0, 16, 1'b1, 5, 1'b1);

    // Async reset while the first of three sub-bursts is on offer.
    trans_valid = 1'b1;
    trans_addr  = 32'h0;
    trans_len   = 16'd1500;
    trans_write = 1'b0;
    @(negedge clk);
    trans_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", sub_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", sub_valid, 0);
    chk("mid_rst_ready", trans_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(32'h100, 8, 1'b1, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: tcs = 10;
        1: tcs = 16;
        2: tcs = 17;
        3: tcs = 665;
        default: tcs = 60 + int'($urandom_range(0, 600));
      endcase
      len = (tcs <= 17) ? int'($urandom_range(0, 48)) : int'($urandom_range(0, 1200));
      case ($urandom_range(0, 3))
        0: addr = $urandom_range(0, 32'h80_0200);
        1: addr = 32'h3F_FF00 + $urandom_range(0, 32'h1FF);
        2: addr = 32'h7F_FF00 + $urandom_range(0, 32'h1FF);
        default: addr = $urandom;
      endcase
      cfg.t_cs_max = 16'(tcs);
      run_txn(addr, len, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
